// File: rtl/ddr3_test_pkg.sv
// ============================================================================
// Package     : ddr3_test_pkg
// Description : Types and constants shared by the DDR3 read-back checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr3_test_pkg;

    // Checker sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2
    } chk_state_t;

    // Mismatch counter sticks at this value instead of wrapping
    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

endpackage : ddr3_test_pkg

`default_nettype wire

// File: rtl/check_timeout.sv
// ============================================================================
// Module      : check_timeout
// Description : Counts idle cycles between valid read words while checking
//               is active and raises a sticky stall flag once the count
//               reaches TIMEOUT. The counter saturates at TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module check_timeout #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic check_en_i,
    input  logic rd_valid_i,
    output logic timeout_o
);

    logic [23:0] idle_cnt_q;
    logic [23:0] idle_cnt_d;
    logic        timeout_q;

    // Next idle count: cleared outside checking or on a valid word, else saturating increment
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!check_en_i || rd_valid_i) begin
            idle_cnt_d = 24'd0;
        end else if (idle_cnt_q != TIMEOUT) begin
            idle_cnt_d = idle_cnt_q + 24'd1;
        end
    end

    // Idle counter register and sticky stall flag
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= 24'd0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            if (check_en_i && !rd_valid_i && (idle_cnt_d == TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;

endmodule : check_timeout

`default_nettype wire

// File: rtl/testdata_check.sv
// ============================================================================
// Module      : testdata_check
// Description : Compares words read back from the DDR3 read FIFO against an
//               incrementing pattern, counting mismatches and completed
//               passes, and flags read-back stalls.
//               Optional macro CHECK_FIRST_ERR_EN builds registers that
//               capture the expected/received values of the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module testdata_check
    import ddr3_test_pkg::*;
#(
    parameter int                  DATA_W    = 16,
    parameter logic [DATA_W-1:0]   PAT_START = 16'd0,
    parameter logic [15:0]         PASS_LEN  = 16'd2201,
    parameter logic [23:0]         TIMEOUT   = 24'd1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calib_done,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err_flag,
    output logic [15:0]       err_cnt,
    output logic [15:0]       pass_cnt,
    output logic              pass_done,
    output logic              timeout,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got
);

    localparam logic [DATA_W-1:0] EXP_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    chk_state_t        state_q;
    logic [DATA_W-1:0] exp_q;
    logic [15:0]       word_cnt_q;
    logic [15:0]       err_cnt_q;
    logic [15:0]       pass_cnt_q;
    logic              err_flag_q;
    logic              pass_done_q;

    logic              w_accept;
    logic              w_mismatch;
    logic              w_last;

    // A word is checked only while armed/checking with calibration still held
    assign w_accept   = calib_done && rd_valid && (state_q != ST_IDLE);
    assign w_mismatch = w_accept && (rd_data != exp_q);
    assign w_last     = (word_cnt_q == (PASS_LEN - 16'd1));

    // Sequencer, pattern tracking and result counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            exp_q       <= PAT_START;
            word_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
            pass_cnt_q  <= 16'd0;
            err_flag_q  <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            pass_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (calib_done) begin
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_CHECK: begin
                    if (!calib_done) begin
                        // Counters, flags and pattern position are kept
                        state_q <= ST_IDLE;
                    end else if (rd_valid) begin
                        state_q <= ST_CHECK;
                        if (w_last) begin
                            word_cnt_q  <= 16'd0;
                            exp_q       <= PAT_START;
                            pass_cnt_q  <= pass_cnt_q + 16'd1;
                            pass_done_q <= 1'b1;
                        end else begin
                            word_cnt_q  <= word_cnt_q + 16'd1;
                            exp_q       <= exp_q + EXP_ONE;
                        end
                        if (w_mismatch) begin
                            err_flag_q <= 1'b1;
                            if (err_cnt_q != ERR_CNT_MAX) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    check_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_check_timeout (
        .clk        (clk),
        .rst        (rst),
        .check_en_i (state_q == ST_CHECK),
        .rd_valid_i (rd_valid),
        .timeout_o  (timeout)
    );

`ifdef CHECK_FIRST_ERR_EN
    logic              first_err_seen_q;
    logic [DATA_W-1:0] first_err_exp_q;
    logic [DATA_W-1:0] first_err_got_q;

    // Capture the first mismatch after reset, then freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_seen_q <= 1'b0;
            first_err_exp_q  <= '0;
            first_err_got_q  <= '0;
        end else if (w_mismatch && !first_err_seen_q) begin
            first_err_seen_q <= 1'b1;
            first_err_exp_q  <= exp_q;
            first_err_got_q  <= rd_data;
        end
    end

    assign first_err_exp = first_err_exp_q;
    assign first_err_got = first_err_got_q;
`else
    assign first_err_exp = '0;
    assign first_err_got = '0;
`endif

    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
    assign pass_cnt  = pass_cnt_q;
    assign pass_done = pass_done_q;

endmodule : testdata_check

`default_nettype wire

// File: tb/tb_testdata_check.sv
// ============================================================================
// Module      : tb_testdata_check
// Description : Directed self-checking bench for testdata_check with
//               PASS_LEN=4 and TIMEOUT=10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_testdata_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        calib_done = 1'b0;
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = 16'd0;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] pass_cnt;
    logic        pass_done;
    logic        timeout;
    logic [15:0] first_err_exp;
    logic [15:0] first_err_got;

    int n_checks = 0;
    int n_fail   = 0;

    testdata_check #(
        .DATA_W    (16),
        .PAT_START (16'd0),
        .PASS_LEN  (16'd4),
        .TIMEOUT   (24'd10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .calib_done    (calib_done),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .err_flag      (err_flag),
        .err_cnt       (err_cnt),
        .pass_cnt      (pass_cnt),
        .pass_done     (pass_done),
        .timeout       (timeout),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid word for one cycle, then valid drops
    task automatic feed(input logic [15:0] d);
        rd_valid = 1'b1;
        rd_data  = d;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        calib_done = 1'b0;
        rd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_err_flag", {31'd0, err_flag}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        check("rst_pass_done", {31'd0, pass_done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_first_exp", {16'd0, first_err_exp}, 32'd0);

        // Clean pass 0,1,2,3
        calib_done = 1'b1;
        tick();
        feed(16'd0); feed(16'd1); feed(16'd2);
        check("p1_no_done_early", {31'd0, pass_done}, 32'd0);
        feed(16'd3);
        check("p1_pass_done", {31'd0, pass_done}, 32'd1);
        check("p1_pass_cnt", {16'd0, pass_cnt}, 32'd1);
        check("p1_err_cnt", {16'd0, err_cnt}, 32'd0);
        tick();
        check("p1_done_pulse", {31'd0, pass_done}, 32'd0);

        // Pass with a mismatch on word 2: 0,1,7,3
        feed(16'd0); feed(16'd1); feed(16'd7);
        check("p2_err_flag", {31'd0, err_flag}, 32'd1);
        check("p2_err_cnt_mid", {16'd0, err_cnt}, 32'd1);
        feed(16'd3);
        check("p2_err_cnt", {16'd0, err_cnt}, 32'd1);
        check("p2_pass_cnt", {16'd0, pass_cnt}, 32'd2);
`ifdef CHECK_FIRST_ERR_EN
        check("p2_first_exp", {16'd0, first_err_exp}, 32'd2);
        check("p2_first_got", {16'd0, first_err_got}, 32'd7);
`else
        check("p2_first_exp", {16'd0, first_err_exp}, 32'd0);
        check("p2_first_got", {16'd0, first_err_got}, 32'd0);
`endif

        // Mismatch on the final word updates both counters together
        feed(16'd0); feed(16'd1); feed(16'd2);
        check("p3_err_before_last", {16'd0, err_cnt}, 32'd1);
        feed(16'd9);
        check("p3_err_cnt", {16'd0, err_cnt}, 32'd2);
        check("p3_pass_cnt", {16'd0, pass_cnt}, 32'd3);
        check("p3_pass_done", {31'd0, pass_done}, 32'd1);
`ifdef CHECK_FIRST_ERR_EN
        check("p3_first_frozen", {16'd0, first_err_got}, 32'd7);
`endif

        // Timeout: 9 idle cycles then a word keeps it clear; 10 idle sets it
        do_reset();
        calib_done = 1'b1;
        tick();
        feed(16'd0);
        idle(9);
        check("to_9_idle", {31'd0, timeout}, 32'd0);
        feed(16'd1);
        check("to_after_word", {31'd0, timeout}, 32'd0);
        idle(9);
        check("to_9_again", {31'd0, timeout}, 32'd0);
        idle(1);
        check("to_10_idle", {31'd0, timeout}, 32'd1);
        idle(3);
        check("to_sticky", {31'd0, timeout}, 32'd1);

        // Reset mid-pass discards partial state
        do_reset();
        calib_done = 1'b1;
        tick();
        feed(16'd0); feed(16'd1); feed(16'd2);
        do_reset();
        check("mid_rst_timeout", {31'd0, timeout}, 32'd0);
        calib_done = 1'b1;
        tick();
        feed(16'd0); feed(16'd1); feed(16'd2); feed(16'd3);
        check("mid_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("mid_pass_cnt", {16'd0, pass_cnt}, 32'd1);

        // rd_valid with calib_done low is ignored
        calib_done = 1'b0;
        tick();
        feed(16'hDEAD); feed(16'hBEEF); feed(16'h1234); feed(16'h5555);
        check("nocal_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("nocal_err_flag", {31'd0, err_flag}, 32'd0);
        check("nocal_pass_cnt", {16'd0, pass_cnt}, 32'd1);
        calib_done = 1'b1;
        tick();
        feed(16'd0); feed(16'd1); feed(16'd2); feed(16'd3);
        check("recal_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("recal_pass_cnt", {16'd0, pass_cnt}, 32'd2);

        // Saturation: 70000 wrong words
        do_reset();
        calib_done = 1'b1;
        tick();
        for (int i = 0; i < 70000; i++) begin
            rd_valid = 1'b1;
            rd_data  = 16'(i % 4) ^ 16'h8000;
            tick();
        end
        rd_valid = 1'b0;
        check("sat_err_cnt", {16'd0, err_cnt}, 32'h0000FFFF);
        check("sat_err_flag", {31'd0, err_flag}, 32'd1);
        check("sat_pass_cnt", {16'd0, pass_cnt}, 32'd17500);
        feed(16'h8000);
        check("sat_hold", {16'd0, err_cnt}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_testdata_check

`default_nettype wire
